// File: rtl/color_scan_sequencer.sv
// Single-FSM TCS3200 scan controller: steps the filter through blue, green, red and clear, counts
// sensor edges per gate window, weights each count and classifies the dominant colour.
module color_scan_sequencer #(
  parameter int unsigned GATE_CYCLES   = 6250000,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned W_BLUE        = 30,
  parameter int unsigned W_GREEN       = 35,
  parameter int unsigned W_RED         = 21,
  parameter int unsigned W_CLEAR       = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              colorsignal,
  output logic              S2,
  output logic              S3,
  output logic [CNT_W+5:0]  blue_val,
  output logic [CNT_W+5:0]  green_val,
  output logic [CNT_W+5:0]  red_val,
  output logic [CNT_W+5:0]  clear_val,
  output logic [2:0]        color_code,
  output logic              valid,
  output logic              busy
);

  localparam int unsigned ValW = CNT_W + 6;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [2:0] {StIdle, StSettle, StGate, StStore, StDecide} state_e;
  typedef enum logic [1:0] {ChBlue, ChGreen, ChRed, ChClear} chan_e;

  state_e            state_q, state_d;
  chan_e             chan_q, chan_d;
  logic [31:0]       timer_q, timer_d;
  logic              sync1_q, sync2_q, hist_q, edge_det;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        weight;
  logic [ValW-1:0]   product;
  logic [ValW-1:0]   hold_q [4];
  logic [ValW-1:0]   blue_q, green_q, red_q, clear_q;
  logic [2:0]        code_q, code_d;
  logic              valid_q;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      chan_q  <= ChBlue;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          chan_d  = ChBlue;
          timer_d = '0;
        end
      end
      StSettle: begin
        if (timer_q == SETTLE_CYCLES - 32'd1) begin
          state_d = StGate;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StGate: begin
        if (timer_q == GATE_CYCLES - 32'd1) begin
          state_d = StStore;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StStore: begin
        if (chan_q == ChClear) begin
          state_d = StDecide;
        end else begin
          state_d = StSettle;
          chan_d  = chan_e'(chan_q + 2'd1);
        end
      end
      StDecide: begin
        chan_d  = ChBlue;
        state_d = start ? StSettle : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: filter select follows the registered channel, so it only moves on SETTLE/IDLE entry
  always_comb begin
    busy = (state_q != StIdle);
    unique case (chan_q)
      ChBlue:  {S2, S3} = 2'b01;
      ChGreen: {S2, S3} = 2'b11;
      ChRed:   {S2, S3} = 2'b00;
      ChClear: {S2, S3} = 2'b10;
      default: {S2, S3} = 2'b01;
    endcase
  end

  assign edge_det = sync2_q & ~hist_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StGate) begin
      if (edge_det && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    unique case (chan_q)
      ChBlue:  weight = 6'(W_BLUE);
      ChGreen: weight = 6'(W_GREEN);
      ChRed:   weight = 6'(W_RED);
      ChClear: weight = 6'(W_CLEAR);
      default: weight = '0;
    endcase
  end

  assign product = ValW'(cnt_q) * ValW'(weight);

  // Strict maximum wins; any tie for the top falls through to 4
  always_comb begin
    logic [ValW-1:0] b, g, r, c;
    b = hold_q[ChBlue];
    g = hold_q[ChGreen];
    r = hold_q[ChRed];
    c = hold_q[ChClear];
    if (r > g && r > b && r > c)      code_d = 3'd1;
    else if (g > r && g > b && g > c) code_d = 3'd2;
    else if (b > r && b > g && b > c) code_d = 3'd3;
    else                              code_d = 3'd4;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
      blue_q  <= '0;
      green_q <= '0;
      red_q   <= '0;
      clear_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= colorsignal;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      cnt_q   <= cnt_d;
      if (state_q == StStore) hold_q[chan_q] <= product;
      if (state_q == StDecide) begin
        blue_q  <= hold_q[ChBlue];
        green_q <= hold_q[ChGreen];
        red_q   <= hold_q[ChRed];
        clear_q <= hold_q[ChClear];
        code_q  <= code_d;
      end
      valid_q <= (state_q == StDecide);
    end
  end

  assign blue_val   = blue_q;
  assign green_val  = green_q;
  assign red_val    = red_q;
  assign clear_val  = clear_q;
  assign color_code = code_q;
  assign valid      = valid_q;

endmodule

// File: doc/color_scan_sequencer.md
# color_scan_sequencer

Controller that owns the TCS3200-style colour sensor. It steps the photodiode filter select (S2/S3) through blue, green, red and clear, in that order. For each filter it waits a settle time, then counts rising edges of `colorsignal` over a fixed gate window and scales each count by a per-channel weight. After all four channels it issues a one-cycle classification result (red/green/blue/clear) to the motion controller. It replaces the four free-running per-colour counters with a single shared counter under one FSM.

## Interface
- `GATE_CYCLES`, default 6250000: clocks per counting window.
- `SETTLE_CYCLES`, default 1000: clocks after a filter change before counting starts.
- `CNT_W`, default 16: raw edge-counter width.
- `W_BLUE` / `W_GREEN` / `W_RED` / `W_CLEAR`, defaults 30 / 35 / 21 / 12: channel weights, each < 64.
- `clock`  in  1  system clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; scans run back-to-back while high.
- `colorsignal`  in  1  sensor frequency output, asynchronous to `clock`.
- `S2`, `S3`  out  1 each  filter select.
- `blue_val`, `green_val`, `red_val`, `clear_val`  out  CNT_W+6 each  weighted channel results.
- `color_code`  out  3  0 = none yet, 1 = red, 2 = green, 3 = blue, 4 = clear/undecided.
- `valid`  out  1  one-cycle pulse when results and `color_code` update.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset (async) values:
  - state = IDLE
  - S2 = 0, S3 = 1 (blue filter)
  - all `*_val` = 0, `color_code` = 0
  - `valid` = 0, `busy` = 0
  - synchronizer flops and counters = 0
- Input conditioning: `colorsignal` passes through a 2-flop synchronizer plus one history flop. An edge is counted when the history flop is 0 and the second synchronizer flop is 1.
- Filter encoding (S2,S3): blue = 0,1; green = 1,1; red = 0,0; clear = 1,0. The encoding is driven from state entry and held constant through SETTLE, GATE and STORE of that channel.
- FSM states:
  - **IDLE**: if `start` = 1 → SETTLE with channel = blue.
  - **SETTLE**: timer counts SETTLE_CYCLES clocks; the edge counter is held at 0. → GATE.
  - **GATE**: timer counts GATE_CYCLES clocks; each detected edge increments the edge counter. The counter saturates at 2^CNT_W−1 and does not wrap. → STORE.
  - **STORE** (1 clock): latch count × weight into an internal per-channel holding register; clear the counter. If channel ≠ clear → SETTLE with the next channel, else → DECIDE.
  - **DECIDE** (1 clock): copy the holding registers to the `*_val` outputs, compute `color_code`, and assert `valid` on the following cycle. Then → SETTLE with blue if `start` = 1, else → IDLE with S2,S3 = blue.
- Classification compares the weighted values:
  - 1 if red is strictly greater than each of the other three.
  - Otherwise 2 if green is strictly greater than each of the other three.
  - Otherwise 3 if blue is strictly greater than each of the other three.
  - Otherwise 4. Any tie for the maximum gives 4.
- Arithmetic: product width is CNT_W+6, unsigned, no truncation.
- `start` falling mid-scan does not abort; the current scan completes through DECIDE, then the block idles.
- Outputs hold their last result between `valid` pulses.
- Reset asserted mid-scan returns everything to reset values immediately. Partial counts are discarded and no `valid` is produced.

## Timing
- Per channel: SETTLE_CYCLES + GATE_CYCLES + 1 clocks.
- Scan latency: with `start` sampled high in IDLE at edge k, `valid` is high in the cycle after edge k + 4·(SETTLE_CYCLES + GATE_CYCLES + 1) + 1, for exactly one cycle.
- Back-to-back scans: consecutive `valid` pulses are 4·(SETTLE_CYCLES + GATE_CYCLES + 1) + 1 clocks apart.
- `*_val` and `color_code` change only in the cycle `valid` is high.
- Edge-count latency: the synchronizer delays detection by 3 clocks. An edge is counted if and only if its detect pulse falls inside a GATE cycle.
- S2/S3 change only on the clock entering SETTLE.

## Test plan
All scenarios use GATE_CYCLES = 100, SETTLE_CYCLES = 4, CNT_W = 8.
- **Reset:** assert `reset` async mid-GATE → same cycle: S2,S3 = 0,1, `busy` = 0, `color_code` = 0; no `valid` afterward until a new `start`.
- **Red dominant:** `colorsignal` period 10 during red, period 50 otherwise; `start` held → red_val = 210, blue_val = 60, green_val = 70, clear_val = 24, color_code = 1, `valid` one cycle at k + 421.
- **Tie:** equal weighted red and green maxima (e.g. red 5 edges → 105, green 3 edges → 105) → color_code = 4.
- **Saturation:** `colorsignal` toggling every clock during blue (≈50 edges, raise to CNT_W = 4) → blue count saturates at 15, blue_val = 450, no wrap.
- **Start drop:** deassert `start` during green of the first scan → that scan completes, `valid` pulses once, state returns to IDLE, `busy` = 0, S2,S3 = 0,1.
- **Filter sequence:** monitor S2,S3 over one scan → 01 → 11 → 00 → 10, each held exactly 105 clocks.
